dac_stream_tx: RTL and testbench
================================

DAC_STREAM_TX -- requirements
Module: dac_stream_tx

Interface
REQ-001 Parameter: DATA_W, default 16, sample width in bits, legal range 8..32.
REQ-002 Parameter: SLOT_W, default 32, BCLK periods per LRCK half-period, legal range DATA_W..64; slot bits beyond DATA_W are 0.
REQ-003 Parameter: MODE, default 1; 0 = LSB-first from the LRCK edge, 1 = I2S (MSB-first, one-BCLK delay), 2 = left-justified (MSB-first, no delay).
REQ-004 Parameter: MONO, default 0; when 1, both channels transmit sample_l and sample_r is ignored.
REQ-005 Clock and reset: one clock, BCLK; reset is synchronous and active-high. All state updates on the BCLK rising edge.
REQ-006 BCLK  input  1  bit clock, the only clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 enable  input  1  playback enable.
REQ-009 DACLRCK  input  1  frame clock from the codec; low = left, high = right; synchronous to BCLK.
REQ-010 sample_l  input  DATA_W  left sample, two's complement.
REQ-011 sample_r  input  DATA_W  right sample, two's complement.
REQ-012 sample_valid  input  1  stereo pair offered.
REQ-013 sample_ready  output  1  block accepts the pair this cycle.
REQ-014 DACDAT  output  1  registered serial data; never Z.
REQ-015 underrun  output  1  one-cycle pulse: a frame started with no pair buffered.
REQ-016 underrun_cnt  output  8  saturating count of underrun pulses.
REQ-017 busy  output  1  high while a loaded frame is being shifted.

Function
REQ-018 Edge detection: lrck_q SHALL register DACLRCK every cycle. edge = DACLRCK != lrck_q. The detection cycle is k=0; k increments by 1 per cycle and saturates at SLOT_W. k restarts at 0 on every edge.
REQ-019 Buffering: the block SHALL hold one pending pair and one active pair. sample_ready = enable & !pending_full. A transfer occurs on sample_valid & sample_ready.
REQ-020 Frame start, on a falling edge with enable high:
- If a pair is pending, it moves to active and pending becomes empty.
- Otherwise active is cleared to 0 and underrun pulses for one cycle.
REQ-021 Frame start on the same cycle as a transfer: a transfer is only possible when pending is empty. The pair loads into pending, not active, and an underrun is still flagged for that frame.
REQ-022 Channel select: the left slot SHALL use the active left sample. The right slot SHALL use the active right sample, or the active left sample when MONO=1.
REQ-023 DACDAT at slot cycle k:
- MODE2: bit DATA_W-1-k for k<DATA_W.
- MODE1: bit DATA_W-k for 1<=k<=DATA_W.
- MODE0: bit k for k<DATA_W.
- All other k: 0.
REQ-024 Right-slot edges (rising) SHALL NOT load pairs or flag underrun.
REQ-025 enable low:
- DACDAT = 0 and sample_ready = 0.
- No loads and no underrun counting.
- The pending pair is retained.
- Raising enable takes effect at the next falling edge.
REQ-026 busy SHALL be high from the load cycle until k reaches SLOT_W in the right slot. busy SHALL drop immediately when enable falls.
REQ-027 underrun_cnt SHALL increment on each underrun pulse and saturate at 255.
REQ-028 A DACLRCK period shorter than DATA_W+1 BCLKs SHALL truncate the slot with no error; the remaining bits are dropped.

Reset
REQ-029 While reset is high, the block SHALL drive DACDAT=0, sample_ready=0, underrun=0, underrun_cnt=0 and busy=0. It SHALL also set lrck_q=0, k=SLOT_W, pending empty and active=0.
REQ-030 Reset SHALL dominate all other inputs, including mid-frame. The first cycle after reset release accepts data if enable=1.
REQ-031 A rising edge detected right after reset SHALL output 0s and not count as an underrun.

Verification
REQ-032 MODE=1, DATA_W=16, pair L=16'hA5C3, R=16'h0001 preloaded, DACLRCK falls -> DACDAT at k=1..16 = 1010010111000011; k=0 and k=17..31 = 0. Right slot k=16 = 1; all other right-slot bits 0.
REQ-033 MODE=2, then MODE=0, same pair -> MSB at k=0 for MODE=2; LSB (1) at k=0 for MODE=0; 16 bits each, then zeros.
REQ-034 No pair supplied, 3 falling edges with enable=1 -> 3 underrun pulses, underrun_cnt=3, DACDAT all 0. After 300 empty frames, underrun_cnt=255.
REQ-035 Back-to-back valid: pair A is accepted, sample_ready=0 until the next falling edge; pair B is accepted the cycle after A loads. Consecutive frames carry A then B.
REQ-036 Reset asserted at left-slot k=8 -> DACDAT=0 next cycle, underrun_cnt=0, pending empty. The next frame after release with no data -> underrun=1.
REQ-037 MONO=1, L=16'h8000, R=16'h7FFF -> both slots transmit 8000. enable dropped mid-frame -> DACDAT=0 and busy=0 next cycle.

Source files
------------

// File: rtl/dac_stream_tx.sv
// dac_stream_tx: serial transmitter that feeds a codec DAC. It buffers one
// stereo pair behind the pair being sent. On every left-slot (falling
// DACLRCK) edge it starts a new frame and shifts the pair out on DACDAT
// using the selected bit alignment.
//
// Ports
//   BCLK          bit clock. This is the only clock; all state changes on its rising edge.
//   reset         synchronous, active-high.
//   enable        playback enable. A rise takes effect at the next left-slot edge.
//   DACLRCK       frame clock from the codec: low = left slot, high = right slot.
//   sample_l/r    two's-complement samples. sample_r is ignored when MONO=1.
//   sample_valid  a stereo pair is offered.
//   sample_ready  the pending buffer can take the offered pair this cycle.
//   DACDAT        registered serial data.
//   underrun      one-cycle pulse: a left-slot frame started with nothing buffered.
//   underrun_cnt  count of underrun pulses; it stops at 255.
//   busy          high while a loaded frame is still being shifted out.
//
// Handshake: a pair transfers on a rising BCLK edge where sample_valid and
// sample_ready are both high. sample_ready does not depend on sample_valid.
// The source may drop or change an offer that has not been taken.
`timescale 1ns/1ps
module dac_stream_tx #(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 32,
  parameter int MODE   = 1,
  parameter int MONO   = 0
) (
  input  logic              BCLK,
  input  logic              reset,
  input  logic              enable,
  input  logic              DACLRCK,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              DACDAT,
  output logic              underrun,
  output logic [7:0]        underrun_cnt,
  output logic              busy
);

  localparam int KW = $clog2(SLOT_W + 1);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [KW-1:0] K_SAT = KW'(SLOT_W);
  localparam logic [KW-1:0] K_DW  = KW'(DATA_W);

  logic              lrck_q;
  logic [KW-1:0]     k_q, k_cur, k_next;
  logic              lrck_edge, frame_start, load, starve, xfer;
  logic              pend_full;
  logic [DATA_W-1:0] pend_l, pend_r, act_l, act_r;
  logic [DATA_W-1:0] act_l_next, act_r_next, slot_word;
  logic [KW-1:0]     bit_pos;
  logic              in_range, serial_bit;
  logic              busy_next, dacdat_q, underrun_q, busy_q;
  logic [7:0]        cnt_q;

  // The edge-detection cycle is slot position 0. The position saturates at
  // SLOT_W, so an over-long slot only sends zeros.
  assign lrck_edge = DACLRCK ^ lrck_q;
  assign k_cur     = lrck_edge ? '0 : k_q;
  assign k_next    = (k_cur == K_SAT) ? K_SAT : k_cur + 1'b1;

  assign frame_start  = lrck_edge & ~DACLRCK & enable;
  assign load         = frame_start & pend_full;
  assign starve       = frame_start & ~pend_full;
  assign sample_ready = enable & ~pend_full & ~reset;
  assign xfer         = sample_valid & sample_ready;

  // The active pair as it will be after this edge. The bit sent at k=0 must
  // already come from the pair that loads in this same cycle.
  always_comb begin
    act_l_next = act_l;
    act_r_next = act_r;
    if (!enable || starve) begin
      act_l_next = '0;
      act_r_next = '0;
    end else if (load) begin
      act_l_next = pend_l;
      act_r_next = pend_r;
    end
  end

  assign slot_word = (DACLRCK && MONO == 0) ? act_r_next : act_l_next;

  always_comb begin
    bit_pos  = k_cur;
    in_range = 1'b0;
    if (MODE == 2) begin
      bit_pos  = K_DW - k_cur - 1'b1;
      in_range = k_cur < K_DW;
    end else if (MODE == 1) begin
      bit_pos  = K_DW - k_cur;
      in_range = (k_cur != '0) && (k_cur <= K_DW);
    end else begin
      bit_pos  = k_cur;
      in_range = k_cur < K_DW;
    end
    serial_bit = in_range ? slot_word[IW'(bit_pos)] : 1'b0;
  end

  // busy marks a frame that carries real data. It ends when the right
  // slot's position reaches SLOT_W.
  always_comb begin
    busy_next = busy_q;
    if (!enable)                              busy_next = 1'b0;
    else if (load)                            busy_next = 1'b1;
    else if (starve)                          busy_next = 1'b0;
    else if (DACLRCK && (k_next == K_SAT))    busy_next = 1'b0;
  end

  always_ff @(posedge BCLK) begin
    if (reset) begin
      lrck_q     <= 1'b0;
      k_q        <= K_SAT;
      pend_full  <= 1'b0;
      pend_l     <= '0;
      pend_r     <= '0;
      act_l      <= '0;
      act_r      <= '0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q      <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      lrck_q <= DACLRCK;
      k_q    <= k_next;
      act_l  <= act_l_next;
      act_r  <= act_r_next;
      // A frame start and a transfer in the same cycle can only happen with
      // pending empty. The new pair then waits in pending.
      if (load) begin
        pend_full <= 1'b0;
      end else if (xfer) begin
        pend_full <= 1'b1;
        pend_l    <= sample_l;
        pend_r    <= sample_r;
      end
      dacdat_q   <= enable & serial_bit;
      underrun_q <= starve;
      if (starve && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      busy_q     <= busy_next;
    end
  end

  assign DACDAT       = dacdat_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dac_stream_tx.sv
`timescale 1ns/1ps
module tb_dac_stream_tx;

  localparam int DW = 16;
  localparam int SW = 32;
  localparam int NI = 4;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  logic rst, en, lrck, valid;
  logic [DW-1:0] l, r;
  logic [NI-1:0] dat_w, rdy_w, und_w, busy_w;
  logic [7:0] cnt_w [NI];

  initial forever #5 clk = ~clk;

  // Four builds share the stimulus: I2S, left-justified, LSB-first, I2S mono.
  function automatic int mode_of(int i);
    case (i)
      1: return 2;
      2: return 0;
      default: return 1;
    endcase
  endfunction
  function automatic bit mono_of(int i);
    return (i == 3);
  endfunction

  dac_stream_tx #(.DATA_W(DW), .SLOT_W(SW), .MODE(1), .MONO(0)) u_i2s (
    .BCLK(clk), .reset(rst), .enable(en), .DACLRCK(lrck), .sample_l(l), .sample_r(r),
    .sample_valid(valid), .sample_ready(rdy_w[0]), .DACDAT(dat_w[0]), .underrun(und_w[0]),
    .underrun_cnt(cnt_w[0]), .busy(busy_w[0]));
  dac_stream_tx #(.DATA_W(DW), .SLOT_W(SW), .MODE(2), .MONO(0)) u_lj (
    .BCLK(clk), .reset(rst), .enable(en), .DACLRCK(lrck), .sample_l(l), .sample_r(r),
    .sample_valid(valid), .sample_ready(rdy_w[1]), .DACDAT(dat_w[1]), .underrun(und_w[1]),
    .underrun_cnt(cnt_w[1]), .busy(busy_w[1]));
  dac_stream_tx #(.DATA_W(DW), .SLOT_W(SW), .MODE(0), .MONO(0)) u_lsb (
    .BCLK(clk), .reset(rst), .enable(en), .DACLRCK(lrck), .sample_l(l), .sample_r(r),
    .sample_valid(valid), .sample_ready(rdy_w[2]), .DACDAT(dat_w[2]), .underrun(und_w[2]),
    .underrun_cnt(cnt_w[2]), .busy(busy_w[2]));
  dac_stream_tx #(.DATA_W(DW), .SLOT_W(SW), .MODE(1), .MONO(1)) u_mono (
    .BCLK(clk), .reset(rst), .enable(en), .DACLRCK(lrck), .sample_l(l), .sample_r(r),
    .sample_valid(valid), .sample_ready(rdy_w[3]), .DACDAT(dat_w[3]), .underrun(und_w[3]),
    .underrun_cnt(cnt_w[3]), .busy(busy_w[3]));

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int n_acc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending pairs {left,right}; the model keeps at most one.
  logic [31:0] exp_q[$];
  bit          m_init = 0;
  logic        m_lrck;
  int          m_pos;
  logic [DW-1:0] ma_l, ma_r;
  logic        m_busy, m_und;
  int          m_cnt;
  logic [NI-1:0] m_dat;
  int          obs_pos;
  logic        obs_right;
  bit          obs_valid = 0;

  // Bit sent at slot position pos, straight from the alignment rules.
  function automatic logic exp_bit(int mode, logic [DW-1:0] w, int pos);
    int idx;
    logic [DW-1:0] t;
    if (mode == 2)      idx = DW - 1 - pos;
    else if (mode == 1) idx = DW - pos;
    else                idx = pos;
    if (idx < 0 || idx >= DW) return 1'b0;
    t = w >> idx;
    return t[0];
  endfunction

  initial begin
    logic [31:0] pair;
    logic [DW-1:0] word;
    bit rdy_now, lr_edge;
    int pos;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        m_init = 1; m_lrck = 0; m_pos = SW; exp_q.delete();
        ma_l = '0; ma_r = '0; m_busy = 0; m_und = 0; m_cnt = 0; m_dat = '0;
        obs_valid = 0;
      end else if (m_init) begin
        rdy_now = en && exp_q.size() == 0;
        lr_edge = (lrck != m_lrck);
        pos = lr_edge ? 0 : m_pos;
        m_und = 0;
        if (!en) begin
          ma_l = '0; ma_r = '0; m_busy = 0;
        end else if (lr_edge && !lrck) begin
          if (exp_q.size() != 0) begin
            pair = exp_q.pop_front();
            ma_l = pair[31:16]; ma_r = pair[15:0]; m_busy = 1;
          end else begin
            ma_l = '0; ma_r = '0; m_busy = 0; m_und = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end
        if (valid && rdy_now) exp_q.push_back({l, r});
        for (int i = 0; i < NI; i++) begin
          word = (lrck && !mono_of(i)) ? ma_r : ma_l;
          m_dat[i] = en ? exp_bit(mode_of(i), word, pos) : 1'b0;
        end
        if (en && lrck && pos + 1 >= SW) m_busy = 0;
        obs_pos = pos; obs_right = lrck; obs_valid = 1;
        m_pos = (pos + 1 > SW) ? SW : pos + 1;
        m_lrck = lrck;
      end
    end
  end

  // ---------------- per-cycle compare + slot capture ----------------
  logic [31:0] cap_l [NI];
  logic [31:0] cap_r [NI];

  initial begin
    logic exp_rdy;
    forever begin
      @(negedge clk);
      if (m_init) begin
        exp_rdy = !rst && en && exp_q.size() == 0;
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("dacdat[%0d]", i), 32'(dat_w[i]), 32'(m_dat[i]));
          chk($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_busy));
          chk($sformatf("underrun[%0d]", i), 32'(und_w[i]), 32'(m_und));
          chk($sformatf("underrun_cnt[%0d]", i), 32'(cnt_w[i]), 32'(m_cnt));
          chk($sformatf("sample_ready[%0d]", i), 32'(rdy_w[i]), 32'(exp_rdy));
          if (obs_valid && obs_pos < 32) begin
            if (obs_right)
              cap_r[i] = (obs_pos == 0 ? 32'h0 : cap_r[i]) | (32'(dat_w[i]) << (31 - obs_pos));
            else
              cap_l[i] = (obs_pos == 0 ? 32'h0 : cap_l[i]) | (32'(dat_w[i]) << (31 - obs_pos));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    bit hold;
    #1;
    hold = (valid === 1'b1) && (rdy_w[0] === 1'b1);
    @(posedge clk);
    #1;
    if (hold) begin
      valid = 1'b0;
      n_acc++;
    end
  endtask

  task automatic offer(input logic [DW-1:0] lv, input logic [DW-1:0] rv);
    valid = 1'b1; l = lv; r = rv;
    tick();
  endtask

  task automatic run_frame(input int nl, input int nr);
    lrck = 1'b0;
    repeat (nl) tick();
    lrck = 1'b1;
    repeat (nr) tick();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_tick();
    if (!valid && $urandom_range(0, 2) == 0) begin
      valid = 1'b1; l = 16'($urandom); r = 16'($urandom);
    end
    if ($urandom_range(0, 199) == 0) en = ~en;
    if (rst) rst = 1'b0;
    else if ($urandom_range(0, 499) == 0) rst = 1'b1;
    tick();
  endtask

  task automatic run_frame_rand(input int nl, input int nr);
    lrck = 1'b0;
    repeat (nl) rand_tick();
    lrck = 1'b1;
    repeat (nr) rand_tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    int acc0;
    rst = 1'b1; en = 1'b1; lrck = 1'b1; valid = 1'b1; l = 16'h1357; r = 16'h2468;
    repeat (3) tick();
    settle();
    chk("reset dacdat", 32'(dat_w), 32'h0);
    chk("reset busy", 32'(busy_w), 32'h0);
    chk("reset underrun", 32'(und_w), 32'h0);
    chk("reset cnt", 32'(cnt_w[0]), 32'h0);
    chk("reset ready", 32'(rdy_w), 32'h0);

    // Release: the first cycle already accepts data.
    rst = 1'b0; en = 1'b1; valid = 1'b0; lrck = 1'b0;
    settle();
    chk("ready after release", 32'(rdy_w[0]), 32'h1);

    // A rising edge right after reset is silent; preload the reference pair.
    lrck = 1'b1;
    offer(16'hA5C3, 16'h0001);
    repeat (3) tick();
    settle();
    chk("no underrun on rising", 32'(cnt_w[0]), 32'h0);

    run_frame(32, 32);
    settle();
    chk("i2s left", cap_l[0], 32'h52E18000);
    chk("lj left", cap_l[1], 32'hA5C30000);
    chk("lsb left", cap_l[2], 32'hC3A50000);
    chk("i2s right", cap_r[0], 32'h00008000);
    chk("lj right", cap_r[1], 32'h00010000);
    chk("lsb right", cap_r[2], 32'h80000000);
    chk("mono right", cap_r[3], 32'h52E18000);

    // Three frames with nothing buffered.
    repeat (3) run_frame(32, 32);
    settle();
    chk("underrun cnt 3", 32'(cnt_w[0]), 32'd3);
    chk("empty left", cap_l[0], 32'h0);
    chk("empty right", cap_r[0], 32'h0);

    // Back-to-back: B waits until A moves into the active slot.
    acc0 = n_acc;
    offer(16'h1234, 16'h5555);
    valid = 1'b1; l = 16'hFEDC; r = 16'hAAAA;
    repeat (3) tick();
    settle();
    chk("ready low while full", 32'(rdy_w[0]), 32'h0);
    run_frame(32, 32);
    settle();
    chk("frame A left", cap_l[0], 32'h091A0000);
    chk("accepted A and B", 32'(n_acc - acc0), 32'd2);
    run_frame(32, 32);
    settle();
    chk("frame B left", cap_l[0], 32'h7F6E0000);

    // Mono and mid-frame disable.
    offer(16'h8000, 16'h7FFF);
    run_frame(32, 32);
    settle();
    chk("mono left", cap_l[3], 32'h40000000);
    chk("mono right", cap_r[3], 32'h40000000);
    chk("stereo right 7fff", cap_r[0], 32'h3FFF8000);
    chk("lj right 7fff", cap_r[1], 32'h7FFF0000);
    offer(16'h00FF, 16'h0F0F);
    lrck = 1'b0;
    repeat (10) tick();
    settle();
    chk("busy mid-frame", 32'(busy_w[0]), 32'h1);
    en = 1'b0;
    tick();
    settle();
    chk("dacdat after disable", 32'(dat_w), 32'h0);
    chk("busy after disable", 32'(busy_w), 32'h0);
    en = 1'b1;
    repeat (10) tick();
    lrck = 1'b1;
    repeat (32) tick();

    // Reset in the middle of a left slot.
    offer(16'h1111, 16'h2222);
    lrck = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    settle();
    chk("mid reset dacdat", 32'(dat_w), 32'h0);
    chk("mid reset cnt", 32'(cnt_w[0]), 32'h0);
    rst = 1'b0;
    settle();
    chk("pending empty after reset", 32'(rdy_w[0]), 32'h1);
    repeat (5) tick();
    lrck = 1'b1;
    repeat (16) tick();
    run_frame(32, 32);
    settle();
    chk("underrun after reset", 32'(cnt_w[0]), 32'd1);

    // Randomized traffic, odd frame lengths, enable and reset toggles.
    for (int f = 0; f < 150; f++) begin
      int nl, nr;
      if (!en && $urandom_range(0, 1) == 1) en = 1'b1;
      nl = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 40) : SW;
      nr = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 40) : SW;
      run_frame_rand(nl, nr);
    end

    // Saturation of the underrun counter.
    rst = 1'b0; en = 1'b1; valid = 1'b0;
    repeat (300) run_frame(4, 4);
    settle();
    for (int i = 0; i < NI; i++)
      chk($sformatf("cnt saturated[%0d]", i), 32'(cnt_w[i]), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
